// File: rtl/legv8_ex_pipe.sv
// LEGv8 execute stage: ALU control decode, operand forwarding, ALU and an EX/MEM
// valid/ready output register. Define LEGV8_EX_MUL_EN to build the iterative multiplier.
module legv8_ex_pipe #(
  parameter int XLEN     = 64,
  parameter int BR_SHIFT = 2,
  parameter int MUL_BPC  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] se,
  input  logic [10:0]     op_code,
  input  logic [1:0]      alu_op,
  input  logic            alu_src,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] mem_fwd,
  input  logic [XLEN-1:0] wb_fwd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            is_zero,
  output logic [XLEN-1:0] br_tar,
  output logic            busy
);

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  typedef enum logic [2:0] {FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_PASS, FN_MUL} alu_fn_e;

  if ((XLEN % MUL_BPC) != 0) begin : g_bad_bpc
    $error("XLEN must be a multiple of MUL_BPC");
  end

  alu_fn_e         fn;
  logic [XLEN-1:0] op_a, fwd_rd2, op_b, alu_res, br_tar_d;
  logic            accept, can_load, is_mul;
  logic            load_single, mul_done;
  logic [XLEN-1:0] mul_res, mul_br;

  assign can_load = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (fn == FN_MUL);
  assign br_tar_d = pc + (se << BR_SHIFT);

  always_comb begin
    // NOTE: every combinational output is given a default first so that no
    // path through the case statements can infer a latch.
    fn = FN_PASS;
    case (alu_op)
      2'b00: fn = FN_ADD;
      2'b10: begin
        case (op_code)
          OPC_SUB: fn = FN_SUB;
          OPC_AND: fn = FN_AND;
          OPC_ORR: fn = FN_ORR;
          OPC_MUL: fn = FN_MUL;
          default: fn = FN_ADD;
        endcase
      end
      default: fn = FN_PASS;
    endcase
  end

  always_comb begin
    op_a    = rd1;
    fwd_rd2 = rd2;
    case (fwd_a)
      2'b01:   op_a = mem_fwd;
      2'b10:   op_a = wb_fwd;
      default: op_a = rd1;
    endcase
    case (fwd_b)
      2'b01:   fwd_rd2 = mem_fwd;
      2'b10:   fwd_rd2 = wb_fwd;
      default: fwd_rd2 = rd2;
    endcase
    op_b = alu_src ? se : fwd_rd2;
  end

  // FN_MUL only reaches this path when the multiplier is not built.
  always_comb begin
    alu_res = '0;
    case (fn)
      FN_ADD:  alu_res = op_a + op_b;
      FN_SUB:  alu_res = op_a - op_b;
      FN_AND:  alu_res = op_a & op_b;
      FN_ORR:  alu_res = op_a | op_b;
      FN_PASS: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef LEGV8_EX_MUL_EN
  localparam int STEPS = XLEN / MUL_BPC;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q, br_pend_q, step_sum;
  logic [CW-1:0]   cnt_q;
  logic            last_step;

  assign step_sum    = acc_q + mcand_q * XLEN'(mplier_q[MUL_BPC-1:0]);
  assign last_step   = (state_q == S_MUL) && (cnt_q == CW'(STEPS - 1));
  assign mul_done    = last_step && can_load;
  assign load_single = accept && !is_mul;
  assign mul_res     = step_sum;
  assign mul_br      = br_pend_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_MUL);
    in_ready = (state_q == S_IDLE) && can_load;
  end

  // The final step is not committed to acc_q; a blocked result is recomputed
  // each cycle from the frozen accumulator until the output register frees up.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      br_pend_q <= '0;
      cnt_q     <= '0;
    end else if (accept && is_mul) begin
      mcand_q   <= op_a;
      mplier_q  <= op_b;
      acc_q     <= '0;
      br_pend_q <= br_tar_d;
      cnt_q     <= '0;
    end else if (state_q == S_MUL && !last_step) begin
      acc_q    <= step_sum;
      mcand_q  <= mcand_q << MUL_BPC;
      mplier_q <= mplier_q >> MUL_BPC;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
`else
  assign busy        = 1'b0;
  assign in_ready    = can_load;
  assign load_single = accept;
  assign mul_done    = 1'b0;
  assign mul_res     = '0;
  assign mul_br      = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      is_zero    <= 1'b0;
      br_tar     <= '0;
    end else if (load_single) begin
      out_valid  <= 1'b1;
      alu_result <= alu_res;
      is_zero    <= (alu_res == '0);
      br_tar     <= br_tar_d;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      alu_result <= mul_res;
      is_zero    <= (mul_res == '0);
      br_tar     <= mul_br;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_legv8_ex_pipe.sv
// Self-checking bench for legv8_ex_pipe: directed scenarios plus a randomized
// stream checked against a queue-based reference model.
module tb_legv8_ex_pipe;

  localparam int XLEN     = 64;
  localparam int BR_SHIFT = 2;
  localparam int MUL_BPC  = 8;
  localparam int STEPS    = XLEN / MUL_BPC;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, alu_src, out_valid, out_ready, is_zero, busy;
  logic [XLEN-1:0] rd1, rd2, pc, se, mem_fwd, wb_fwd, alu_result, br_tar;
  logic [10:0]     op_code;
  logic [1:0]      alu_op, fwd_a, fwd_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] br;
  } exp_t;

  exp_t exp_q[$];

  legv8_ex_pipe #(.XLEN(XLEN), .BR_SHIFT(BR_SHIFT), .MUL_BPC(MUL_BPC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2(rd2), .pc(pc), .se(se), .op_code(op_code), .alu_op(alu_op),
    .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .is_zero(is_zero), .br_tar(br_tar), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] reg_val);
    if (sel == 2'b01) return mem_fwd;
    if (sel == 2'b10) return wb_fwd;
    return reg_val;
  endfunction

  // Reference: result of the currently driven instruction, from the ISA rules.
  function automatic logic [XLEN-1:0] model_res();
    logic [XLEN-1:0] a, b;
    a = pick(fwd_a, rd1);
    b = alu_src ? se : pick(fwd_b, rd2);
    if (alu_op[0]) return b;
    if (alu_op == 2'b00) return a + b;
    case (op_code)
      OPC_SUB: return a - b;
      OPC_AND: return a & b;
      OPC_ORR: return a | b;
`ifdef LEGV8_EX_MUL_EN
      OPC_MUL: return a * b;
`else
      OPC_MUL: return '0;
`endif
      default: return a + b;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] model_br();
    return pc + (se << BR_SHIFT);
  endfunction

  task automatic set_rtype(input logic [10:0] opc, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    op_code = opc; alu_op = 2'b10; alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    rd1 = a; rd2 = b; pc = '0; se = '0; mem_fwd = '0; wb_fwd = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_rtype(OPC_ADD, '0, '0);
    repeat (3) cycle();
    checks++;
    if (out_valid !== 1'b0 || alu_result !== '0 || is_zero !== 1'b0 || br_tar !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b alu_result=%h is_zero=%b br_tar=%h busy=%b, want all 0",
               out_valid, alu_result, is_zero, br_tar, busy);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    set_rtype(OPC_ADD, 64'd5, 64'd7);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 64'd12 || is_zero !== 1'b0) begin
      failures++;
      $display("FAIL add: out_valid=%b alu_result=%0d is_zero=%b, want 1/12/0", out_valid, alu_result, is_zero);
    end
  endtask

  task automatic test_sub_fwd();
    set_rtype(OPC_SUB, 64'h55, 64'd9);
    fwd_a = 2'b01; mem_fwd = 64'd9; pc = 64'h100; se = 64'h10;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    mem_fwd = 64'hDEAD;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== '0 || is_zero !== 1'b1 || br_tar !== 64'h140) begin
      failures++;
      $display("FAIL sub_fwd: out_valid=%b alu_result=%h is_zero=%b br_tar=%h, want 1/0/1/140",
               out_valid, alu_result, is_zero, br_tar);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || alu_result !== '0) begin
      failures++;
      $display("FAIL sub_latch: out_valid=%b alu_result=%h, want 0/0", out_valid, alu_result);
    end
  endtask

`ifdef LEGV8_EX_MUL_EN
  task automatic test_mul();
    int bad = 0;
    set_rtype(OPC_MUL, '1, 64'd3);
    pc = 64'h200; se = 64'h4;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    rd1 = '0; rd2 = '0; pc = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) bad++;
      cycle();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mul_busy: %0d of %0d cycles had wrong in_ready/busy/out_valid, want 0", bad, STEPS);
    end
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 64'hFFFF_FFFF_FFFF_FFFD || busy !== 1'b0 || br_tar !== 64'h210) begin
      failures++;
      $display("FAIL mul_result: out_valid=%b alu_result=%h busy=%b br_tar=%h, want 1/fffffffffffffffd/0/210",
               out_valid, alu_result, busy, br_tar);
    end
    cycle();
  endtask

  task automatic test_reset_mid_mul();
    int bad = 0;
    set_rtype(OPC_MUL, 64'd11, 64'd13);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_mul: out_valid=%b busy=%b in_ready=%b, want 0/0/1", out_valid, busy, in_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < STEPS + 4; i++) begin
      cycle();
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_mul_no_result: out_valid high in %0d cycles, want 0", bad);
    end
  endtask
`else
  task automatic test_mul();
    set_rtype(OPC_MUL, '1, 64'd3);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== '0 || is_zero !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mul_disabled: out_valid=%b alu_result=%h is_zero=%b busy=%b, want 1/0/1/0",
               out_valid, alu_result, is_zero, busy);
    end
    cycle();
  endtask
`endif

  task automatic test_backpressure();
    logic [XLEN-1:0] a, b;
    int bad = 0;
    a = rnd(); b = rnd();
    out_ready = 1'b0;
    set_rtype(OPC_ADD, a, b);
    in_valid = 1'b1;
    cycle();
    set_rtype(OPC_ADD, 64'd1, 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || alu_result !== a + b || in_ready !== 1'b0) bad++;
      cycle();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: %0d bad cycles, alu_result=%h want %h", bad, alu_result, a + b);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release_ready: got %b want 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 64'd2) begin
      failures++;
      $display("FAIL backpressure_next: out_valid=%b alu_result=%0d, want 1/2", out_valid, alu_result);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_rtype(OPC_ADD, 64'(k), 64'(k));
      in_valid = 1'b1;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 64'(2 * k)) begin
        failures++;
        $display("FAIL back_to_back_%0d: out_valid=%b alu_result=%0d, want 1/%0d", k, out_valid, alu_result, 2 * k);
      end
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [10:0]     opcs[6];
    logic            held = 1'b0;
    logic [XLEN-1:0] held_res, held_br;
    logic            held_z;
    exp_t            e;
    opcs[0] = OPC_ADD; opcs[1] = OPC_SUB; opcs[2] = OPC_AND;
    opcs[3] = OPC_ORR; opcs[4] = OPC_MUL; opcs[5] = 11'h000;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || alu_result !== held_res || br_tar !== held_br || is_zero !== held_z) begin
          failures++;
          $display("FAIL rand_hold_%0d: alu_result=%h br_tar=%h, want %h %h", i, alu_result, br_tar, held_res, held_br);
        end
      end
      op_code = opcs[$urandom_range(0, 5)];
      if (op_code == 11'h000) op_code = 11'($urandom);
      alu_op = 2'($urandom_range(0, 7) < 5 ? 2 : $urandom_range(0, 3));
      alu_src = 1'($urandom_range(0, 3) == 0);
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      rd1 = ($urandom_range(0, 7) == 0) ? '0 : rnd();
      rd2 = ($urandom_range(0, 7) == 0) ? rd1 : rnd();
      pc = rnd(); se = rnd(); mem_fwd = rnd(); wb_fwd = rnd();
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      if (busy === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL rand_busy_ready_%0d: in_ready=%b want 0 while busy", i, in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected_%0d: result %h with nothing outstanding", i, alu_result);
        end else begin
          e = exp_q.pop_front();
          if (alu_result !== e.res || br_tar !== e.br || is_zero !== (e.res == '0)) begin
            failures++;
            $display("FAIL rand_result_%0d: alu_result=%h br_tar=%h is_zero=%b, want %h %h %b",
                     i, alu_result, br_tar, is_zero, e.res, e.br, (e.res == '0));
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        e.res = model_res();
        e.br  = model_br();
        exp_q.push_back(e);
      end
      held = (out_valid === 1'b1) && !out_ready;
      held_res = alu_result; held_br = br_tar; held_z = is_zero;
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * STEPS && exp_q.size() != 0; i++) begin
      #1;
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (alu_result !== e.res || br_tar !== e.br) begin
          failures++;
          $display("FAIL rand_drain: alu_result=%h br_tar=%h, want %h %h", alu_result, br_tar, e.res, e.br);
        end
      end
      cycle();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_lost: %0d results never delivered, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_fwd();
    test_mul();
    test_backpressure();
`ifdef LEGV8_EX_MUL_EN
    test_reset_mid_mul();
`endif
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
